// File: rtl/pipe_pkg.sv
// Shared pipeline package: occupancy/state encodings, default payload width and
// per-stage payload packing structs.
package pipe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StBusy  = ST_BUSY,
    StFull  = ST_FULL
  } buf_state_e;

  // M->W stage payload, packed by the caller into in_data.
  typedef struct packed {
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        reg_write;
    logic [31:0] pc;
  } mw_payload_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable, synchronous clear and asynchronous clear,
// both clears loading FLUSH_VAL.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= FLUSH_VAL;
    end else if (clear) begin
      data_q <= FLUSH_VAL;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with registered payload and flush. Defining
// PIPE_STAGE_BUF_SKID_EN adds a skid register so in_ready is fully registered.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  buf_state_e        state_q, state_d;
  logic              in_xfer, out_xfer;
  logic              main_en;
  logic [DATA_W-1:0] main_d, main_q;
  logic              skid_en;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

`ifdef PIPE_STAGE_BUF_SKID_EN
  logic              in_ready_q;
  logic [DATA_W-1:0] skid_q;

  // in_ready comes from a flop so it never depends on out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != StFull);
    end
  end
  assign in_ready = in_ready_q;

  pipe_data_reg #(
    .DATA_W    (DATA_W),
    .FLUSH_VAL (FLUSH_VAL)
  ) u_skid_reg (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = in_data;
    skid_en = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d = StBusy;
          main_en = 1'b1;
        end
      end
      StBusy: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (out_xfer) begin
          // Main reg keeps the consumed word so out_data is stable while empty.
          state_d = StEmpty;
`ifdef PIPE_STAGE_BUF_SKID_EN
        end else if (in_xfer) begin
          state_d = StFull;
          skid_en = 1'b1;
`endif
        end
      end
`ifdef PIPE_STAGE_BUF_SKID_EN
      StFull: begin
        if (out_xfer) begin
          state_d = StBusy;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
`endif
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_reg #(
    .DATA_W    (DATA_W),
    .FLUSH_VAL (FLUSH_VAL)
  ) u_main_reg (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf; expectations come from a queue-based
// buffer model, valid for both the skid and the default build.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  logic [31:0] last_d;

`ifdef PIPE_STAGE_BUF_SKID_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  pipe_stage_buf #(
    .DATA_W    (32),
    .FLUSH_VAL (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, clock, update model.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic fl, output logic acc);
    logic exp_ir, exp_ov;
    logic [31:0] popped;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_ov = (mq.size() != 0);
`ifdef PIPE_STAGE_BUF_SKID_EN
    exp_ir = (mq.size() < 2);
`else
    exp_ir = (mq.size() == 0) || ordy;
`endif
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    chk("occupancy", {30'b0, occupancy}, mq.size());
    chk("out_data", out_data, exp_ov ? mq[0] : last_d);
    @(posedge clk);
    acc = !fl && iv && exp_ir;
    if (fl) begin
      mq.delete();
      last_d = 32'h0;
    end else begin
      if (exp_ov && ordy) begin
        popped = mq.pop_front();
        last_d = popped;
      end
      if (iv && exp_ir) mq.push_back(id);
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, ordy, 1'b0, acc);
  endtask

  task automatic fill_to_cap(input logic [31:0] base);
    logic acc;
    for (int i = 0; i < Cap; i++) begin
      cycle(1'b1, base + i, 1'b0, 1'b0, acc);
      chk("fill_accept", {31'b0, acc}, 32'd1);
    end
  endtask

  initial begin : stim
    logic        acc;
    logic [31:0] bp_words [3];
    int          idx;

    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    last_d    = 32'h0;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with a one-cycle lag.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h100 + i, 1'b1, 1'b0, acc);
      chk("stream_accept", {31'b0, acc}, 32'd1);
      chk("stream_occ", {30'b0, occupancy}, 32'd1);
    end
    idle(2, 1'b1);

    // Backpressure: offer 0xA,0xB,0xC, re-offering rejected words.
    bp_words[0] = 32'hA;
    bp_words[1] = 32'hB;
    bp_words[2] = 32'hC;
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, bp_words[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_held", idx, Cap);
    for (int i = 0; i < 20 && idx < 3; i++) begin
      cycle(1'b1, bp_words[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 32'd3);
    idle(4, 1'b1);

    // Stall hold.
    cycle(1'b1, 32'h55, 1'b0, 1'b0, acc);
    idle(10, 1'b0);
    chk("stall_data", out_data, 32'h55);
    idle(2, 1'b1);

    // Flush with a concurrent in-transfer offer.
    fill_to_cap(32'h200);
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b1, acc);
    chk("flush_occ", {30'b0, occupancy}, 32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    idle(3, 1'b1);

    // Asynchronous reset mid-cycle while full.
    fill_to_cap(32'h300);
    #3 reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_occupancy", {30'b0, occupancy}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_out_data", out_data, 32'h0);
    mq.delete();
    last_d = 32'h0;
    in_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h77, 1'b1, 1'b0, acc);
    chk("post_rst_latency", out_data, 32'h77);

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), acc);
    end
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter FLUSH_VAL, default 0, value loaded into payload registers on flush/reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous kill of all held entries (interrupt/exception request).
REQ-006 SHALL have port in_valid  input  1  upstream stage presents a word.
REQ-007 SHALL have port in_ready  output  1  this stage accepts the word this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload (WD, WR, RegWrite, PC packed by caller).
REQ-009 SHALL have port out_valid  output  1  downstream word present.
REQ-010 SHALL have port out_ready  input  1  downstream stage consumes the word this cycle.
REQ-011 SHALL have port out_data  output  DATA_W  downstream payload, registered.
REQ-012 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-013 SHALL transfer in on in_valid&&in_ready and out on out_valid&&out_ready, both at the rising edge.
REQ-014 SHALL implement states EMPTY (occ 0), BUSY (occ 1), FULL (occ 2); occupancy SHALL equal the state encoding.
REQ-015 EMPTY: in-transfer -> BUSY, word in main reg; no transfer -> EMPTY.
REQ-016 BUSY: in only -> FULL (word to skid reg); out only -> EMPTY; in+out -> BUSY with new word in main reg.
REQ-017 FULL: out-transfer -> BUSY, skid word moved to main reg; in_ready SHALL be 0 so no in-transfer.
REQ-018 out_valid SHALL be 1 exactly when state != EMPTY; out_data SHALL be main reg contents.
REQ-019 in_ready SHALL be registered (state != FULL), never combinationally dependent on out_ready.
REQ-020 Latency SHALL be 1 cycle in->out when EMPTY; throughput 1 word/cycle when out_ready held 1.
REQ-021 Order SHALL be preserved; no word duplicated or dropped except by flush.
REQ-022 flush SHALL take priority over all transfers: next state EMPTY, both regs := FLUSH_VAL, concurrent in-transfer discarded.
REQ-023 out_data SHALL hold its value when state unchanged and no transfer (stall).
REQ-024 When EMPTY, out_data SHALL be FLUSH_VAL after reset/flush, else last consumed word.

Reset
REQ-025 On reset low, SHALL immediately force EMPTY, occupancy 0, out_valid 0, in_ready 1, both regs FLUSH_VAL, independent of clk.
REQ-026 Reset mid-operation SHALL discard held entries; first in-transfer after release follows REQ-015.
REQ-027 Reset release SHALL be synchronised externally; block adds no synchroniser.

Configuration
REQ-028 Macro PIPE_STAGE_BUF_SKID_EN SHALL select the skid variant.
REQ-029 With PIPE_STAGE_BUF_SKID_EN defined: behaviour as REQ-014..REQ-024.
REQ-030 Without it: skid reg and FULL state absent; in_ready = !out_valid || out_ready (combinational); occupancy max 1; flush/reset rules unchanged.

Structure
REQ-031 Shared package pipe_pkg SHALL hold state encoding constants (ST_EMPTY=0, ST_BUSY=1, ST_FULL=2) and default DATA_W.
REQ-032 Payload packing structs per stage (M->W fields) SHALL live in pipe_pkg, not in this block.
REQ-033 One sub-module pipe_data_reg (DATA_W register with enable, async clear to FLUSH_VAL) SHALL be instantiated for main and skid regs.

Verification
REQ-034 Reset: reset=0 mid-run with occ 2 -> same cycle out_valid=0, occupancy=0, in_ready=1, out_data=0.
REQ-035 Streaming: out_ready=1, in_valid=1 data 0x100..0x107 -> out_data 0x100..0x107 on consecutive cycles, 1-cycle lag, occupancy 1.
REQ-036 Backpressure: out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 after 2nd, occupancy 2; out_ready=1 -> 0xA,0xB,0xC in order.
REQ-037 Flush: occ 2 and flush=1 with in_valid=1 data 0xDEAD -> next cycle occupancy 0, out_valid 0, 0xDEAD never emitted.
REQ-038 Stall hold: occ 1 data 0x55, out_ready=0 for 10 cycles -> out_data stays 0x55, out_valid 1.
REQ-039 Skid off build: out_ready=0, occ 1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, occupancy never 2.
